asymmetric_wr_fifo: RTL and testbench

Narrow-in / wide-out width-converting FIFO; successor to the asymmetric write RAM. Packs DATA_RATIO narrow words into one wide line and queues lines in a FIFO_DEPTH-entry buffer. Partial lines can be committed early via in_if_last. Sits between the narrow streaming producers (e.g. operand loaders) and the wide matrix-multiply datapath, using valid/ready handshakes on both sides.

---
 rtl/asymmetric_wr_fifo.sv | 131 +++++++++++++
 tb/tb_asymmetric_wr_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asymmetric_wr_fifo.sv
// Narrow-in / wide-out width-converting FIFO: packs DATA_RATIO words per line, FWFT output.
// Define ASYM_FIFO_IDLE_FLUSH_EN to commit a partial line after IDLE_CYCLES idle cycles.
module asymmetric_wr_fifo #(
  parameter int DATA_RATIO  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int IDLE_CYCLES = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_if_valid,
  output logic                                  in_if_ready,
  input  logic [DATA_WIDTH-1:0]                 in_if_data,
  input  logic                                  in_if_last,
  output logic                                  out_if_valid,
  input  logic                                  out_if_ready,
  output logic [DATA_RATIO-1:0][DATA_WIDTH-1:0] out_if_data,
  output logic [DATA_RATIO-1:0]                 out_if_keep,
  output logic                                  out_if_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       level
);
  localparam int LW = $clog2(DATA_RATIO);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [DATA_RATIO-1:0][DATA_WIDTH-1:0] r_pack;
  logic [LW-1:0]                         r_lane_idx;
  logic [PW-1:0]                         r_wr_ptr;
  logic [PW-1:0]                         r_rd_ptr;
  logic [CW-1:0]                         r_level;
  logic                                  r_in_ready;
  logic [DATA_RATIO-1:0][DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [DATA_RATIO-1:0]                 r_mem_keep [FIFO_DEPTH];
  logic                                  r_mem_last [FIFO_DEPTH];

  logic                                  w_in_xfer;
  logic                                  w_in_commit;
  logic                                  w_flush;
  logic                                  w_commit;
  logic                                  w_pop;
  logic [CW-1:0]                         w_level_next;
  logic [DATA_RATIO-1:0][DATA_WIDTH-1:0] w_line;
  logic [DATA_RATIO-1:0]                 w_line_keep;
  logic                                  w_line_last;

  assign w_in_xfer    = in_if_valid & r_in_ready;
  assign w_in_commit  = w_in_xfer & ((r_lane_idx == LW'(DATA_RATIO-1)) | in_if_last);
  assign w_pop        = (r_level != '0) & out_if_ready;
  assign w_commit     = w_in_commit | w_flush;
  assign w_level_next = r_level + CW'(w_commit) - CW'(w_pop);

`ifdef ASYM_FIFO_IDLE_FLUSH_EN
  localparam int IW = $clog2(IDLE_CYCLES+1);
  logic [IW-1:0] r_idle_cnt;
  logic          w_idle;

  // The counter saturates one below the threshold so a flush blocked by a full buffer fires as soon as space frees.
  assign w_idle  = (r_lane_idx != '0) & ~w_in_xfer;
  assign w_flush = w_idle & (r_idle_cnt == IW'(IDLE_CYCLES-1)) & (r_level < CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (!w_idle || w_flush) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IW'(IDLE_CYCLES-1)) begin
      r_idle_cnt <= r_idle_cnt + IW'(1);
    end
  end
`else
  logic w_unused_idle;
  assign w_unused_idle = (IDLE_CYCLES > 0);
  assign w_flush       = 1'b0;
`endif

  // Line to store: pack lanes below lane_idx, plus the incoming word when this is an input commit.
  always_comb begin
    w_line      = r_pack;
    w_line_keep = '0;
    w_line_last = 1'b0;
    for (int i = 0; i < DATA_RATIO; i++) begin
      if (LW'(i) < r_lane_idx) w_line_keep[i] = 1'b1;
    end
    if (w_in_xfer) begin
      w_line[r_lane_idx]      = in_if_data;
      w_line_keep[r_lane_idx] = 1'b1;
      w_line_last             = in_if_last;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer) r_pack[r_lane_idx] <= in_if_data;
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem_data[r_wr_ptr] <= w_line;
      r_mem_keep[r_wr_ptr] <= w_line_keep;
      r_mem_last[r_wr_ptr] <= w_line_last;
    end
  end

  // Ready is registered from the next level so a commit that fills the buffer blocks the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_idx <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_commit) begin
        r_lane_idx <= '0;
        r_wr_ptr   <= r_wr_ptr + PW'(1);
      end else if (w_in_xfer) begin
        r_lane_idx <= r_lane_idx + LW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level    <= w_level_next;
      r_in_ready <= (w_level_next < CW'(FIFO_DEPTH));
    end
  end

  assign in_if_ready  = r_in_ready;
  assign out_if_valid = (r_level != '0);
  assign out_if_data  = r_mem_data[r_rd_ptr];
  assign out_if_keep  = out_if_valid ? r_mem_keep[r_rd_ptr] : '0;
  assign out_if_last  = out_if_valid & r_mem_last[r_rd_ptr];
  assign level        = r_level;

endmodule

// File: tb/tb_asymmetric_wr_fifo.sv
// Self-checking bench for asymmetric_wr_fifo: vector table, directed corner sequences and a
// randomized run, all compared against a queue-based line model.
module tb_asymmetric_wr_fifo;
  localparam int R    = 8;
  localparam int W    = 32;
  localparam int D    = 16;
  localparam int IDLE = 16;
  localparam int CW   = $clog2(D+1);
  localparam int BW   = R*W;

  logic                clk;
  logic                rst_n;
  logic                in_if_valid;
  logic                in_if_ready;
  logic [W-1:0]        in_if_data;
  logic                in_if_last;
  logic                out_if_valid;
  logic                out_if_ready;
  logic [R-1:0][W-1:0] out_if_data;
  logic [R-1:0]        out_if_keep;
  logic                out_if_last;
  logic [CW-1:0]       level;

  asymmetric_wr_fifo #(
    .DATA_RATIO (R),
    .DATA_WIDTH (W),
    .FIFO_DEPTH (D),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if_valid (in_if_valid),
    .in_if_ready (in_if_ready),
    .in_if_data  (in_if_data),
    .in_if_last  (in_if_last),
    .out_if_valid(out_if_valid),
    .out_if_ready(out_if_ready),
    .out_if_data (out_if_data),
    .out_if_keep (out_if_keep),
    .out_if_last (out_if_last),
    .level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [R-1:0][W-1:0] data;
    logic [R-1:0]        keep;
    logic                last;
  } line_t;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         l;
    logic         ordy;
    logic         expValid;
    logic [R-1:0] expKeep;
    logic         expLast;
    int           expLevel;
    logic         expReady;
  } vec_t;

  line_t               mq[$];
  logic [R-1:0][W-1:0] mPack;
  int                  mLane;
  int                  mIdle;
  bit                  mReady;
  int                  total;
  int                  bad;

  task automatic cmp(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model works on whole lines: words accumulate in a pack array, closed lines go onto a queue.
  task automatic modelStep(input logic v, input logic [W-1:0] d, input logic l, input logic ordy);
    line_t ln;
    int    sizeBefore;
    bit    xfer;
    sizeBefore = mq.size();
    xfer = v && mReady;
    if (sizeBefore != 0 && ordy) void'(mq.pop_front());
    if (xfer) begin
      mPack[mLane] = d;
      mLane++;
      mIdle = 0;
      if (mLane == R || l) begin
        ln.data = mPack;
        ln.keep = R'((1 << mLane) - 1);
        ln.last = l;
        mq.push_back(ln);
        mLane = 0;
      end
    end
`ifdef ASYM_FIFO_IDLE_FLUSH_EN
    else if (mLane != 0) begin
      mIdle++;
      if (mIdle >= IDLE && sizeBefore < D) begin
        ln.data = mPack;
        ln.keep = R'((1 << mLane) - 1);
        ln.last = 1'b0;
        mq.push_back(ln);
        mLane = 0;
        mIdle = 0;
      end
    end
`endif
    mReady = (mq.size() < D);
  endtask

  task automatic checkOutput();
    line_t       head;
    logic [BW-1:0] mask;
    cmp("in_if_ready", BW'(in_if_ready), BW'(mReady));
    cmp("out_if_valid", BW'(out_if_valid), BW'(mq.size() != 0));
    cmp("level", BW'(level), BW'(mq.size()));
    if (mq.size() != 0) begin
      head = mq[0];
      cmp("out_if_keep", BW'(out_if_keep), BW'(head.keep));
      cmp("out_if_last", BW'(out_if_last), BW'(head.last));
      mask = '0;
      for (int i = 0; i < R; i++) if (head.keep[i]) mask[i*W +: W] = '1;
      cmp("out_if_data", out_if_data & mask, head.data & mask);
    end else begin
      cmp("out_if_keep_empty", BW'(out_if_keep), '0);
      cmp("out_if_last_empty", BW'(out_if_last), '0);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic l, input logic ordy);
    in_if_valid  = v;
    in_if_data   = d;
    in_if_last   = l;
    out_if_ready = ordy;
    @(posedge clk);
    if (rst_n) modelStep(v, d, l, ordy);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst_n        = 1'b0;
    in_if_valid  = 1'b0;
    in_if_data   = '0;
    in_if_last   = 1'b0;
    out_if_ready = 1'b0;
    mq.delete();
    mLane  = 0;
    mIdle  = 0;
    mReady = 1'b0;
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] timeout");
  end

  vec_t vecs [6];
  int   waited;
  bit   seen;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1};
    vecs[1] = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1};
    vecs[2] = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1, 1'b1};
    vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1};
    vecs[4] = '{1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1, 1'b1};
    vecs[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1};

    rst_n        = 1'b1;
    in_if_valid  = 1'b0;
    in_if_data   = '0;
    in_if_last   = 1'b0;
    out_if_ready = 1'b0;
    #2;
    doReset();
    cmp("reset_ready", BW'(in_if_ready), '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    cmp("ready_after_release", BW'(in_if_ready), BW'(1));

    $display("[TB] full line of 8 words");
    for (int i = 0; i < R; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b0);
    cmp("line8_level", BW'(level), BW'(1));
    cmp("line8_keep", BW'(out_if_keep), BW'(8'hFF));
    cmp("line8_last", BW'(out_if_last), '0);
    for (int i = 0; i < R; i++) cmp("line8_lane", BW'(out_if_data[i]), BW'(i));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    cmp("line8_level_after_pop", BW'(level), '0);

    $display("[TB] vector table");
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        cmp("partial_lane0", BW'(out_if_data[0]), BW'(32'hA));
        cmp("partial_lane1", BW'(out_if_data[1]), BW'(32'hB));
        cmp("partial_lane2", BW'(out_if_data[2]), BW'(32'hC));
      end
      applyStimulus(vecs[k].v, vecs[k].d, vecs[k].l, vecs[k].ordy);
      cmp("vec_valid", BW'(out_if_valid), BW'(vecs[k].expValid));
      cmp("vec_keep", BW'(out_if_keep), BW'(vecs[k].expKeep));
      cmp("vec_last", BW'(out_if_last), BW'(vecs[k].expLast));
      cmp("vec_level", BW'(level), BW'(vecs[k].expLevel));
      cmp("vec_ready", BW'(in_if_ready), BW'(vecs[k].expReady));
    end

    $display("[TB] fill to full");
    for (int i = 0; i < D*R; i++) applyStimulus(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
    cmp("full_level", BW'(level), BW'(D));
    cmp("full_ready", BW'(in_if_ready), '0);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
    cmp("full_reject_level", BW'(level), BW'(D));
    cmp("full_head_lane0", BW'(out_if_data[0]), BW'(32'h100));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    cmp("pop_reraises_ready", BW'(in_if_ready), BW'(1));
    cmp("pop_level", BW'(level), BW'(D-1));
    for (int i = 0; i < D-1; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    cmp("drained_level", BW'(level), '0);
    for (int i = 0; i < R; i++) applyStimulus(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
    cmp("after_full_lane0", BW'(out_if_data[0]), BW'(32'h200));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] full-rate streaming with wrap");
    for (int i = 0; i < 40*R; i++) begin
      applyStimulus(1'b1, W'(32'h3000 + i), 1'b0, 1'b1);
      if ((i % R) == R-1) cmp("stream_level_le1", BW'(level <= CW'(1)), BW'(1));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] reset mid-line");
    for (int i = 0; i < 3*R + 5; i++) applyStimulus(1'b1, W'(32'h400 + i), 1'b0, 1'b0);
    cmp("pre_reset_level", BW'(level), BW'(3));
    doReset();
    cmp("midreset_valid", BW'(out_if_valid), '0);
    cmp("midreset_level", BW'(level), '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < R; i++) applyStimulus(1'b1, W'(32'h500 + i), 1'b0, 1'b0);
    cmp("post_reset_keep", BW'(out_if_keep), BW'(8'hFF));
    cmp("post_reset_lane0", BW'(out_if_data[0]), BW'(32'h500));
    cmp("post_reset_lane7", BW'(out_if_data[7]), BW'(32'h507));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(logic'($urandom_range(0, 3) != 0), W'($urandom),
                    logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 1)));
    end

    $display("[TB] idle partial line");
    doReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h78, 1'b0, 1'b0);
`ifdef ASYM_FIFO_IDLE_FLUSH_EN
    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      waited++;
      if (out_if_valid) seen = 1'b1;
    end
    cmp("idle_flush_delay", BW'(waited), BW'(IDLE));
    cmp("idle_flush_keep", BW'(out_if_keep), BW'(8'h03));
    cmp("idle_flush_last", BW'(out_if_last), '0);
`else
    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      if (out_if_valid) seen = 1'b1;
    end
    cmp("idle_no_output", BW'(seen), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
